memory_stage: RTL

//  MIPS MEM stage. Consumes the EX/MEM latch outputs and performs data-memory

---
 rtl/memory_stage_if.sv | 54 +++++
 rtl/memory_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/memory_stage_if.sv
// ---------------------------------------------------------------------------
// memory_stage_if
// Bundles the EX/MEM latch inputs, the MEM/WB latch outputs, the forwarding
// bus and the debug read port of the MIPS MEM stage.
//   slave  : the MEM stage itself (consumes i_*, drives o_*)
//   master : whatever feeds the stage (drives i_*, observes o_*)
// Signals:
//   i_halt, i_pcplus4, i_result, i_dato2, i_writeRegister, i_memToReg,
//   i_regWrite, i_memWrite, i_memRead, i_memSize, i_memUnsigned, i_dbg_addr
//   o_dbg_data, o_fwd_dato_mem, o_pcplus4, o_result, o_readData,
//   o_writeRegister, o_memToReg, o_regWrite, o_misaligned
// ---------------------------------------------------------------------------
interface memory_stage_if #(
    parameter int ADDR_W = 8
);
    logic              i_halt;
    logic [31:0]       i_pcplus4;
    logic [31:0]       i_result;
    logic [31:0]       i_dato2;
    logic [4:0]        i_writeRegister;
    logic              i_memToReg;
    logic              i_regWrite;
    logic              i_memWrite;
    logic              i_memRead;
    logic [1:0]        i_memSize;
    logic              i_memUnsigned;
    logic [ADDR_W-1:0] i_dbg_addr;

    logic [31:0]       o_dbg_data;
    logic [31:0]       o_fwd_dato_mem;
    logic [31:0]       o_pcplus4;
    logic [31:0]       o_result;
    logic [31:0]       o_readData;
    logic [4:0]        o_writeRegister;
    logic              o_memToReg;
    logic              o_regWrite;
    logic              o_misaligned;

    modport slave (
        input  i_halt, i_pcplus4, i_result, i_dato2, i_writeRegister,
               i_memToReg, i_regWrite, i_memWrite, i_memRead, i_memSize,
               i_memUnsigned, i_dbg_addr,
        output o_dbg_data, o_fwd_dato_mem, o_pcplus4, o_result, o_readData,
               o_writeRegister, o_memToReg, o_regWrite, o_misaligned
    );

    modport master (
        output i_halt, i_pcplus4, i_result, i_dato2, i_writeRegister,
               i_memToReg, i_regWrite, i_memWrite, i_memRead, i_memSize,
               i_memUnsigned, i_dbg_addr,
        input  o_dbg_data, o_fwd_dato_mem, o_pcplus4, o_result, o_readData,
               o_writeRegister, o_memToReg, o_regWrite, o_misaligned
    );
endinterface

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
// MIPS MEM stage: byte/half/word loads (signed or unsigned) and stores into a
// DEPTH x 32-bit little-endian data memory, followed by the MEM/WB latch.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-low; clears the MEM/WB latch only
//   bus  : memory_stage_if.slave
//          i_* : EX/MEM latch contents, halt, debug word address
//          o_fwd_dato_mem : i_result straight back to the EX forwarding mux
//          o_dbg_data     : combinational read of mem[i_dbg_addr]
//          o_*            : registered MEM/WB latch (1 cycle latency)
// ---------------------------------------------------------------------------
module memory_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    memory_stage_if.slave bus
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    // Byte always aligned, half needs a[0]==0, word (and reserved 11) a[1:0]==0.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: is_aligned = 1'b1;
            SIZE_HALF: is_aligned = ~lane[0];
            default:   is_aligned = (lane == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: byte_enables = 4'b0001 << lane;
            SIZE_HALF: byte_enables = lane[1] ? 4'b1100 : 4'b0011;
            default:   byte_enables = 4'b1111;
        endcase
    endfunction

    // Store data is replicated across the word so that whichever lanes the
    // byte enables select already carry the right bytes.
    function automatic logic [31:0] store_lanes(input logic [31:0] data, input logic [1:0] size);
        case (size)
            SIZE_BYTE: store_lanes = {4{data[7:0]}};
            SIZE_HALF: store_lanes = {2{data[15:0]}};
            default:   store_lanes = data;
        endcase
    endfunction

    // Lane selection plus sign/zero extension of load data. Only called for
    // aligned accesses, so a half load never straddles the word.
    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [31:0]        shifted;
        logic signed [7:0]  sbyte;
        logic signed [15:0] shalf;
        logic signed [31:0] sext;
        shifted = word >> {lane, 3'b000};
        sbyte   = shifted[7:0];
        shalf   = shifted[15:0];
        case (size)
            SIZE_BYTE: begin
                sext        = sbyte;
                extend_load = uns ? {24'd0, shifted[7:0]} : sext;
            end
            SIZE_HALF: begin
                sext        = shalf;
                extend_load = uns ? {16'd0, shifted[15:0]} : sext;
            end
            default:   extend_load = word;
        endcase
    endfunction

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic              aligned;
    logic              do_write;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    // Address bits above the word index only wrap the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.i_result[31:ADDR_W+2];

    logic [31:0] pcplus4_d,        pcplus4_q;
    logic [31:0] result_d,         result_q;
    logic [31:0] read_data_d,      read_data_q;
    logic [4:0]  write_register_d, write_register_q;
    logic        mem_to_reg_d,     mem_to_reg_q;
    logic        reg_write_d,      reg_write_q;
    logic        misaligned_d,     misaligned_q;

    assign word_idx = bus.i_result[ADDR_W+1:2];
    assign lane     = bus.i_result[1:0];
    assign rd_word  = mem[word_idx];

    // ---- MEM: address decode, store enables, load extension ----
    always_comb begin
        aligned          = is_aligned(bus.i_memSize, lane);
        misaligned_d     = (bus.i_memRead | bus.i_memWrite) & ~aligned;
        // A stage held in reset or halted must not commit a store.
        do_write         = bus.i_memWrite & aligned & ~bus.i_halt & rst;
        wr_be            = byte_enables(bus.i_memSize, lane);
        wr_data          = store_lanes(bus.i_dato2, bus.i_memSize);

        read_data_d      = 32'd0;
        if (bus.i_memRead & ~bus.i_memWrite & aligned)
            read_data_d  = extend_load(rd_word, bus.i_memSize, lane, bus.i_memUnsigned);

        pcplus4_d        = bus.i_pcplus4;
        result_d         = bus.i_result;
        write_register_d = bus.i_writeRegister;
        mem_to_reg_d     = bus.i_memToReg;
        reg_write_d      = bus.i_regWrite & ~misaligned_d;
    end

    // Data memory: not reset; a store lands at the edge so a load in the
    // following cycle already reads the new contents.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k])
                    mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    // ---- MEM/WB latch ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            pcplus4_q        <= 32'd0;
            result_q         <= 32'd0;
            read_data_q      <= 32'd0;
            write_register_q <= 5'd0;
            mem_to_reg_q     <= 1'b0;
            reg_write_q      <= 1'b0;
            misaligned_q     <= 1'b0;
        end else if (!bus.i_halt) begin
            pcplus4_q        <= pcplus4_d;
            result_q         <= result_d;
            read_data_q      <= read_data_d;
            write_register_q <= write_register_d;
            mem_to_reg_q     <= mem_to_reg_d;
            reg_write_q      <= reg_write_d;
            misaligned_q     <= misaligned_d;
        end
    end

    assign bus.o_pcplus4       = pcplus4_q;
    assign bus.o_result        = result_q;
    assign bus.o_readData      = read_data_q;
    assign bus.o_writeRegister = write_register_q;
    assign bus.o_memToReg      = mem_to_reg_q;
    assign bus.o_regWrite      = reg_write_q;
    assign bus.o_misaligned    = misaligned_q;

    assign bus.o_fwd_dato_mem  = bus.i_result;
    assign bus.o_dbg_data      = mem[bus.i_dbg_addr];

endmodule
